// File: rtl/uart_receiver_if.sv
// Receive-side byte handshake between the UART receiver (master) and its consumer (slave).
interface uart_receiver_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  data_ready;
    logic                  frame_error;
    logic                  overrun;

    modport master (
        output data_out,
        output data_valid,
        output frame_error,
        output overrun,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  frame_error,
        input  overrun,
        output data_ready
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 LSB-first UART receiver: input synchronizer, oversampling tick generator and
// mid-bit sampling FSM, delivering bytes over a valid/ready handshake with error pulses.
module uart_receiver #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int TICK_LIMIT = 326,
    parameter int TICK_WIDTH = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rx,
    uart_receiver_if.master  bus
);
    localparam int S_W = $clog2(OVERSAMPLE);
    localparam int N_W = $clog2(DATA_WIDTH) + 1;

    localparam logic [S_W-1:0]        S_HALF    = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0]        S_LAST    = S_W'(OVERSAMPLE - 1);
    localparam logic [N_W-1:0]        N_LAST    = N_W'(DATA_WIDTH - 1);
    localparam logic [TICK_WIDTH-1:0] TICK_LAST = TICK_WIDTH'(TICK_LIMIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic                  sync1_q, rx_s_q, rx_prev_q;
    logic [1:0]            state_q, state_d;
    logic [TICK_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
    logic [S_W-1:0]        s_cnt_q, s_cnt_d;
    logic [N_W-1:0]        n_cnt_q, n_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  frame_error_q, frame_error_d;
    logic                  overrun_q, overrun_d;
    logic                  tick;

    assign tick = (tick_cnt_q == TICK_LAST);

    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick ? '0 : tick_cnt_q + TICK_WIDTH'(1);
        s_cnt_d       = s_cnt_q;
        n_cnt_d       = n_cnt_q;
        shift_d       = shift_q;
        data_out_d    = data_out_q;
        data_valid_d  = data_valid_q;
        frame_error_d = 1'b0;
        overrun_d     = 1'b0;

        if (data_valid_q && bus.data_ready) begin
            data_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Restarting the tick counter here puts every sample point at a fixed offset from the start edge.
                if (rx_prev_q && !rx_s_q) begin
                    state_d    = START;
                    s_cnt_d    = '0;
                    tick_cnt_d = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_cnt_q == S_HALF) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_cnt_q == S_LAST) begin
                        shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
                        s_cnt_d = '0;
                        if (n_cnt_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_cnt_d = n_cnt_q + N_W'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + S_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_cnt_q == S_LAST) begin
                        state_d = IDLE;
                        s_cnt_d = '0;
                        if (rx_s_q) begin
                            // A load wins over a same-cycle accept; only an unaccepted byte counts as overrun.
                            data_out_d   = shift_q;
                            data_valid_d = 1'b1;
                            overrun_d    = data_valid_q && !bus.data_ready;
                        end else begin
                            frame_error_d = 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + S_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q       <= 1'b1;
            rx_s_q        <= 1'b1;
            rx_prev_q     <= 1'b1;
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            s_cnt_q       <= '0;
            n_cnt_q       <= '0;
            shift_q       <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            sync1_q       <= rx;
            rx_s_q        <= sync1_q;
            rx_prev_q     <= rx_s_q;
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            s_cnt_q       <= s_cnt_d;
            n_cnt_q       <= n_cnt_d;
            shift_q       <= shift_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.frame_error = frame_error_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized frames against a byte-level scoreboard of the UART receiver.
module tb_uart_receiver;
    localparam int TL  = 4;
    localparam int OS  = 16;
    localparam int BIT = TL * OS;
    localparam int LATENCY = 3 + (OS / 2 + 9 * OS) * TL;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic rx    = 1'b1;

    uart_receiver_if #(.DATA_WIDTH(8)) bus ();

    uart_receiver #(
        .DATA_WIDTH(8),
        .OVERSAMPLE(OS),
        .TICK_LIMIT(TL),
        .TICK_WIDTH(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rx(rx),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int valid_cycles, ferr_cnt, ovr_cnt, first_valid_cyc, start_cyc;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always @(posedge clock) cyc = cyc + 1;

    // Inputs change just after a rising edge, so the falling-edge view matches what the next edge uses.
    always @(negedge clock) begin
        if (bus.data_valid) begin
            valid_cycles++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (bus.data_valid && bus.data_ready) got_q.push_back(bus.data_out);
        if (bus.frame_error) ferr_cnt++;
        if (bus.overrun) ovr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        valid_cycles    = 0;
        ferr_cnt        = 0;
        ovr_cnt         = 0;
        first_valid_cyc = -1;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic idle_clocks(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        idle_clocks(BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic check_got(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] d99;
        bus.data_ready = 1'b0;
        clear_counts();

        // Reset state
        idle_clocks(3);
        check("rst_valid", bus.data_valid, 0);
        check("rst_data", bus.data_out, 0);
        check("rst_ferr", bus.frame_error, 0);
        check("rst_ovr", bus.overrun, 0);
        reset = 1'b1;
        idle_clocks(10);

        // 1: single frame, consumer always ready
        bus.data_ready = 1'b1;
        clear_counts();
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        idle_clocks(10);
        check_got("t1");
        check("t1_valid_cycles", valid_cycles, 1);
        check("t1_latency", first_valid_cyc - start_cyc, LATENCY);
        check("t1_ferr", ferr_cnt, 0);
        check("t1_ovr", ovr_cnt, 0);

        // 2: short low glitch must not produce a byte
        clear_counts();
        rx = 1'b0;
        idle_clocks($urandom_range(8, 24));
        rx = 1'b1;
        idle_clocks(100);
        check("t2_glitch_valid", valid_cycles, 0);
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1);
        idle_clocks(10);
        check_got("t2");
        check("t2_ferr", ferr_cnt, 0);

        // 3: bad stop bit, then a good frame
        clear_counts();
        send_frame(8'h0F, 1'b0);
        idle_clocks(BIT);
        check("t3_ferr_pulse", ferr_cnt, 1);
        check("t3_no_valid", valid_cycles, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        idle_clocks(10);
        check_got("t3");
        check("t3_ferr_total", ferr_cnt, 1);

        // 4: consumer stalled, second byte overruns the first
        bus.data_ready = 1'b0;
        clear_counts();
        send_frame(8'h11, 1'b1);
        idle_clocks(5);
        check("t4_valid1", bus.data_valid, 1);
        check("t4_data1", bus.data_out, 8'h11);
        check("t4_ovr1", ovr_cnt, 0);
        send_frame(8'h22, 1'b1);
        idle_clocks(5);
        check("t4_ovr2", ovr_cnt, 1);
        check("t4_data2", bus.data_out, 8'h22);
        check("t4_valid2", bus.data_valid, 1);
        bus.data_ready = 1'b1;
        idle_clocks(1);
        check("t4_cleared", bus.data_valid, 0);
        exp_q.push_back(8'h22);
        check_got("t4");

        // 5: reset in the middle of a frame while a byte is pending
        bus.data_ready = 1'b0;
        b = 8'($urandom_range(0, 255));
        send_frame(b, 1'b1);
        idle_clocks(5);
        check("t5_pending", bus.data_valid, 1);
        d99 = 8'h99;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d99[i]);
        rx = d99[3];
        idle_clocks(BIT / 2);
        reset = 1'b0;
        #1;
        check("t5_rst_valid", bus.data_valid, 0);
        check("t5_rst_data", bus.data_out, 0);
        check("t5_rst_ferr", bus.frame_error, 0);
        check("t5_rst_ovr", bus.overrun, 0);
        rx = 1'b1;
        idle_clocks(3);
        reset = 1'b1;
        bus.data_ready = 1'b1;
        clear_counts();
        idle_clocks(BIT * 12);
        check("t5_abandoned", valid_cycles, 0);
        exp_q.push_back(8'hC7);
        send_frame(8'hC7, 1'b1);
        idle_clocks(10);
        check_got("t5");
        check("t5_ferr", ferr_cnt, 0);

        // 6: back-to-back frames, directed then random, no idle gap
        clear_counts();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h80);
        for (int i = 0; i < 5; i++) exp_q.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < exp_q.size(); i++) send_frame(exp_q[i], 1'b1);
        idle_clocks(20);
        check_got("t6");
        check("t6_ferr", ferr_cnt, 0);
        check("t6_ovr", ovr_cnt, 0);

        // Break: line held low reports a single framing error
        clear_counts();
        rx = 1'b0;
        idle_clocks(BIT * 30);
        check("brk_ferr", ferr_cnt, 1);
        check("brk_valid", valid_cycles, 0);
        rx = 1'b1;
        idle_clocks(BIT);
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(b);
        send_frame(b, 1'b1);
        idle_clocks(10);
        check_got("brk");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
